// File: rtl/imsic_msi_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imsic_msi_decoder: decodes IMSIC seteipnum writes and queues MSIs to files.
// Revision: 1.0
// ----------------------------------------------------------------------------
module imsic_msi_decoder #(
  parameter int unsigned       NR_SRC      = 64,
  parameter int unsigned       NR_IMSICS   = 4,
  parameter int unsigned       NR_VS_FILES = 1,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] M_BASE_ADDR = 32'h2400_0000,
  parameter logic [ADDR_W-1:0] S_BASE_ADDR = 32'h2800_0000,
  parameter int unsigned       FIFO_DEPTH  = 4,
  localparam int unsigned      SRC_W       = $clog2(NR_SRC),
  localparam int unsigned      IMSIC_W     = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
  localparam int unsigned      FILE_W      = $clog2(2 + NR_VS_FILES)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [ADDR_W-1:0]  i_req_addr,
  input  logic [31:0]        i_req_wdata,
  input  logic [3:0]         i_req_be,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_err,
  output logic [31:0]        o_rsp_rdata,
  output logic               o_msi_valid,
  input  logic               i_msi_ready,
  output logic [IMSIC_W-1:0] o_msi_imsic,
  output logic [FILE_W-1:0]  o_msi_file,
  output logic [SRC_W-1:0]   o_msi_num,
  output logic [15:0]        o_drop_cnt
);

  localparam int unsigned       GUEST_BITS = $clog2(NR_VS_FILES + 1);
  localparam int unsigned       PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned       CNT_W      = PTR_W + 1;
  localparam int unsigned       ENT_W      = IMSIC_W + FILE_W + SRC_W;
  localparam logic [ADDR_W:0]   M_SIZE     = (ADDR_W+1)'(NR_IMSICS) << 12;
  localparam logic [ADDR_W:0]   S_SIZE     = (ADDR_W+1)'(NR_IMSICS) << (12 + GUEST_BITS);
  localparam logic [ADDR_W-1:0] GUEST_MASK = ADDR_W'((1 << GUEST_BITS) - 1);

  logic [ADDR_W-1:0]  w_m_off, w_s_off, w_guest;
  logic               w_m_hit, w_s_hit, w_hit;
  logic               w_is_le, w_is_be, w_num_ok;
  logic [31:0]        w_num;
  logic [IMSIC_W-1:0] w_imsic;
  logic [FILE_W-1:0]  w_file;
  logic               w_accept, w_push, w_drop, w_pop, w_reg_write;
  logic [ENT_W-1:0]   w_head;

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  // Address decode: the M region wins if both regions were ever made to overlap.
  always_comb begin
    w_m_off = i_req_addr - M_BASE_ADDR;
    w_s_off = i_req_addr - S_BASE_ADDR;
    w_m_hit = (i_req_addr >= M_BASE_ADDR) && ({1'b0, w_m_off} < M_SIZE);
    w_s_hit = (i_req_addr >= S_BASE_ADDR) && ({1'b0, w_s_off} < S_SIZE);
    w_guest = (w_s_off >> 12) & GUEST_MASK;
    w_hit   = w_m_hit || (w_s_hit && (w_guest <= ADDR_W'(NR_VS_FILES)));
    if (w_m_hit) begin
      w_imsic = IMSIC_W'(w_m_off >> 12);
      w_file  = '0;
    end else begin
      w_imsic = IMSIC_W'(w_s_off >> (12 + GUEST_BITS));
      w_file  = FILE_W'(w_guest + 1'b1);
    end
    w_is_le  = (i_req_addr[11:2] == 10'd0);
    w_is_be  = (i_req_addr[11:2] == 10'd1);
    w_num    = w_is_be ? {i_req_wdata[7:0], i_req_wdata[15:8],
                          i_req_wdata[23:16], i_req_wdata[31:24]} : i_req_wdata;
    w_num_ok = (i_req_be == 4'hF) && ((w_num >> SRC_W) == 32'd0) && (w_num != 32'd0);
  end

  assign o_req_ready = !i_rst && (count_q != CNT_W'(FIFO_DEPTH)) &&
                       !(rsp_valid_q && !i_rsp_ready);
  assign o_msi_valid = (count_q != '0);

  always_comb begin
    w_accept    = i_req_valid && o_req_ready;
    w_reg_write = w_accept && i_req_we && w_hit && (w_is_le || w_is_be);
    w_push      = w_reg_write && w_num_ok;
    w_drop      = w_reg_write && !w_num_ok;
    w_pop       = o_msi_valid && i_msi_ready;

    rsp_valid_d = rsp_valid_q && !i_rsp_ready;
    rsp_err_d   = rsp_err_q && rsp_valid_d;
    if (w_accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !w_hit;
    end

    count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
    mem_d    = mem_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = {w_imsic, w_file, w_num[SRC_W-1:0]};
    end

    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign w_head      = mem_q[rd_ptr_q];
  assign o_msi_num   = o_msi_valid ? w_head[SRC_W-1:0] : '0;
  assign o_msi_file  = o_msi_valid ? w_head[SRC_W +: FILE_W] : '0;
  assign o_msi_imsic = o_msi_valid ? w_head[SRC_W+FILE_W +: IMSIC_W] : '0;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = '0;
  assign o_drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire
